pipe_buffer: RTL

Parametrised elastic pipeline buffer for the xcore stage boundaries (IF/ID, ID/EX, later EX/MEM). It replaces single-entry stage registers such as the fetch/decode latch with a configurable-depth FIFO. The FIFO accepts and delivers one payload per cycle under valid/ready handshakes on both sides. It adds a synchronous flush for branch and trap redirect, and an occupancy count for stall and profiling logic.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_buffer_ram.sv | 42 ++++
 rtl/pipe_buffer.sv | 102 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - stage payload types and depth legality helper shared by the pipeline buffers
package pipe_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } if_id_t;

   localparam int IF_ID_W = $bits(if_id_t);

   // Used by every buffer instance to reject a non power-of-two DEPTH at elaboration.
   function automatic bit is_pow2(input int n);
      return (n > 0) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/pipe_buffer_ram.sv
// rtl/pipe_buffer_ram.sv - DEPTH x DATA_W register array, one write port, asynchronous read
module pipe_buffer_ram #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 2,
   parameter int AW     = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   generate
      if (DEPTH == 1) begin : g_single
         logic unused_addr;
         assign unused_addr = ^{waddr, raddr};

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)  mem[0] <= '0;
            else if (we) mem[0] <= wdata;
         end

         assign rdata = mem[0];
      end else begin : g_multi
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            end else if (we) begin
               mem[waddr] <= wdata;
            end
         end

         assign rdata = mem[raddr];
      end
   endgenerate

endmodule

// File: rtl/pipe_buffer.sv
// rtl/pipe_buffer.sv - elastic valid/ready stage buffer with synchronous flush and occupancy count
module pipe_buffer
   import pipe_pkg::*;
#(
   parameter int DATA_W     = $bits(if_id_t),
   parameter int DEPTH      = 2,
   parameter bit READY_PASS = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          in_data,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_data,
   input  logic                       out_ready,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   generate
      if (!is_pow2(DEPTH)) begin : g_bad_depth
         $error("pipe_buffer: DEPTH must be a power of two and at least 1");
      end
   endgenerate

   logic          full;
   logic          push;
   logic          pop;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;

   assign full      = (count == CW'(DEPTH));
   assign out_valid = (count != '0) && !flush;

   // Only the pass-through variant lets a draining head make room in the same cycle.
   generate
      if (READY_PASS) begin : g_ready_pass
         assign in_ready = (!full || out_ready) && !flush;
      end else begin : g_ready_reg
         assign in_ready = !full && !flush;
      end
   endgenerate

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            count <= '0;
      else if (flush)        count <= '0;
      else if (push && !pop) count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
   end

   // With a single entry the count doubles as the full flag, so no pointers are kept.
   generate
      if (DEPTH > 1) begin : g_ptrs
         logic [AW-1:0] wr_ptr;
         logic [AW-1:0] rd_ptr;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               wr_ptr <= '0;
               rd_ptr <= '0;
            end else if (flush) begin
               wr_ptr <= '0;
               rd_ptr <= '0;
            end else begin
               if (push) wr_ptr <= wr_ptr + AW'(1);
               if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
         end

         assign wr_addr = wr_ptr;
         assign rd_addr = rd_ptr;
      end else begin : g_no_ptrs
         assign wr_addr = '0;
         assign rd_addr = '0;
      end
   endgenerate

   pipe_buffer_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (push),
      .waddr (wr_addr),
      .wdata (in_data),
      .raddr (rd_addr),
      .rdata (out_data)
   );

   a_in_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (in_valid && !in_ready && !flush) |=> (flush || (in_valid && $stable(in_data))));

endmodule
